// File: rtl/pedge_event_q.sv
// pedge_event_q
// Turns one-cycle positive-edge pulses into a stream of discrete events.
// Each pulse is held in a sticky per-bit pending register together with the
// timestamp of its first capture. Pending bits are dispatched lowest index
// first into a small FIFO, whose head is presented on a valid/ready stream.
// Pulses that arrive while their bit is still pending are merged into that
// event. The event is flagged as overflowed, and the merge is counted in a
// saturating drop counter.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   pulse_in   WIDTH one-cycle edge pulses, sampled every rising edge
//   evt_valid  FIFO head holds an event
//   evt_ready  sink accepts the head when evt_valid && evt_ready
//   evt_idx    bit index of the head event
//   evt_ts     timestamp of the first capture of that edge
//   evt_ovf    further pulses on that bit were merged before dispatch
//   pending    current sticky pending bits
//   drop_cnt   saturating count of merged (coalesced) pulses
module pedge_event_q #(
   parameter int WIDTH = 8,
   parameter int TS_W  = 16,
   parameter int DEPTH = 4,
   localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  pulse_in,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [IW-1:0]     evt_idx,
   output logic [TS_W-1:0]   evt_ts,
   output logic              evt_ovf,
   output logic [WIDTH-1:0]  pending,
   output logic [7:0]        drop_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [TS_W-1:0]  ts;
   logic [TS_W-1:0]  cap_ts [WIDTH];
   logic [WIDTH-1:0] ovf;

   logic [IW-1:0]    sel;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [WIDTH-1:0] dispatched;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] coalesce;
   logic [15:0]      coal_cnt;
   logic [15:0]      drop_sum;
   logic [7:0]       drop_next;

   logic [AW:0]      count;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [IW-1:0]    mem_idx [DEPTH];
   logic [TS_W-1:0]  mem_ts  [DEPTH];
   logic             mem_ovf [DEPTH];

   // Free-running timestamp. A pulse sampled at an edge is stamped with the
   // value held before that edge, so the first edge after reset stamps 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts <= '0;
      end else begin
         ts <= ts + 1'b1;
      end
   end

   // Fixed-priority pick of the lowest pending index. The loop scans from the
   // top down, so the last hit (the lowest index) wins. High bits can starve
   // under a steady low-index stream, and that is accepted.
   always_comb begin
      sel = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel = IW'(i);
         end
      end
   end

   // The FIFO handshake. A push may share a cycle with a pop even when the
   // FIFO is full, because the pop frees the slot on the same edge.
   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign pop       = evt_valid && evt_ready;
   assign push      = (|pending) && (!full || pop);
   assign evt_valid = !empty;

   // Classify each bit's pulse for this edge. A bit that is being dispatched
   // now is free again. A pulse on that bit starts a fresh event instead of
   // being merged into the one that is leaving.
   always_comb begin
      dispatched = '0;
      if (push) begin
         dispatched[sel] = 1'b1;
      end
      capture  = pulse_in & (~pending | dispatched);
      coalesce = pulse_in & pending & ~dispatched;
   end

   // Add this cycle's merged pulses to the drop counter. The counter sticks
   // at 255 rather than wrapping, so a large count is never misread as small.
   always_comb begin
      coal_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         coal_cnt = coal_cnt + 16'(coalesce[i]);
      end
      drop_sum  = {8'b0, drop_cnt} + coal_cnt;
      drop_next = (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else begin
         drop_cnt <= drop_next;
      end
   end

   // Per-bit sticky pending state. A capture restarts the event, and it takes
   // priority over clearing on dispatch. A merge only sets the overflow flag
   // and keeps the original timestamp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         ovf     <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cap_ts[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (capture[i]) begin
               pending[i] <= 1'b1;
               cap_ts[i]  <= ts;
               ovf[i]     <= 1'b0;
            end else if (coalesce[i]) begin
               ovf[i]     <= 1'b1;
            end else if (dispatched[i]) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   // Event FIFO storage and pointers. The pointers wrap naturally because
   // DEPTH is a power of two. Storage is cleared on reset, so the head
   // outputs read zero until the first event arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_idx[i] <= '0;
            mem_ts[i]  <= '0;
            mem_ovf[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            mem_idx[wr_ptr] <= sel;
            mem_ts[wr_ptr]  <= cap_ts[sel];
            mem_ovf[wr_ptr] <= ovf[sel];
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The head fields come straight from registered storage, so they stay
   // stable while the sink stalls.
   assign evt_idx = mem_idx[rd_ptr];
   assign evt_ts  = mem_ts[rd_ptr];
   assign evt_ovf = mem_ovf[rd_ptr];

endmodule

// File: tb/tb_pedge_event_q.sv
// tb_pedge_event_q
// Self-checking bench for pedge_event_q. Each expected event is queued when
// the pulse that creates it is driven. The monitor pops the queue and
// compares it against every accepted handshake.
module tb_pedge_event_q;

   localparam int WIDTH = 8;
   localparam int TS_W  = 16;
   localparam int DEPTH = 4;
   localparam int IW    = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] pulse_in = '0;
   logic             evt_ready = 1'b0;
   logic             evt_valid;
   logic [IW-1:0]    evt_idx;
   logic [TS_W-1:0]  evt_ts;
   logic             evt_ovf;
   logic [WIDTH-1:0] pending;
   logic [7:0]       drop_cnt;

   typedef struct {
      logic [IW-1:0]   idx;
      logic [TS_W-1:0] ts;
      logic            ovf;
   } evt_t;

   evt_t expq[$];
   evt_t monE;
   int   numCompared = 0;
   int   numMismatched = 0;

   pedge_event_q #(.WIDTH(WIDTH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pulse_in  (pulse_in),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_idx   (evt_idx),
      .evt_ts    (evt_ts),
      .evt_ovf   (evt_ovf),
      .pending   (pending),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      numCompared++;
      if (got !== exp) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor. It samples on the falling edge, where the handshake that will
   // complete on the next rising edge is stable.
   always @(negedge clk) begin
      if (rst_n && evt_valid && evt_ready) begin
         if (expq.size() == 0) begin
            checkOutput("unexpected_evt", {29'b0, evt_idx}, 32'hFFFF_FFFF);
         end else begin
            monE = expq.pop_front();
            checkOutput("evt_idx", {29'b0, evt_idx}, {29'b0, monE.idx});
            checkOutput("evt_ts", {16'b0, evt_ts}, {16'b0, monE.ts});
            checkOutput("evt_ovf", {31'b0, evt_ovf}, {31'b0, monE.ovf});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a pulse vector and a ready level, then let one rising edge sample them.
   task automatic applyStimulus(input logic [WIDTH-1:0] p, input logic r);
      pulse_in  = p;
      evt_ready = r;
      step();
   endtask

   task automatic expectEvt(input int idx, input int ts, input logic ovf);
      evt_t e;
      e.idx = IW'(idx);
      e.ts  = TS_W'(ts);
      e.ovf = ovf;
      expq.push_back(e);
   endtask

   // Release reset just after a rising edge, so the next edge samples ts=0.
   task automatic doReset();
      rst_n     = 1'b0;
      pulse_in  = '0;
      evt_ready = 1'b0;
      expq.delete();
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Drain with ready held high, within a bounded number of cycles.
   task automatic drain(input string tag, input int maxCycles);
      pulse_in  = '0;
      evt_ready = 1'b1;
      for (int i = 0; i < maxCycles && expq.size() != 0; i++) begin
         step();
      end
      checkOutput({tag, "_drained"}, expq.size(), 0);
      step();
      checkOutput({tag, "_idle_valid"}, {31'b0, evt_valid}, 0);
      checkOutput({tag, "_idle_pending"}, {24'b0, pending}, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Check the reset state.
      doReset();
      checkOutput("rst_valid", {31'b0, evt_valid}, 0);
      checkOutput("rst_pending", {24'b0, pending}, 0);
      checkOutput("rst_drop", {24'b0, drop_cnt}, 0);
      checkOutput("rst_idx", {29'b0, evt_idx}, 0);
      checkOutput("rst_ts", {16'b0, evt_ts}, 0);
      checkOutput("rst_ovf", {31'b0, evt_ovf}, 0);

      // Two bits pulse together at ts=5. Check the latency and the
      // lowest-index-first order.
      for (int i = 0; i < 5; i++) applyStimulus('0, 1'b1);
      expectEvt(4, 5, 1'b0);
      expectEvt(7, 5, 1'b0);
      applyStimulus(8'b1001_0000, 1'b1);
      checkOutput("t1_valid_n", {31'b0, evt_valid}, 0);
      checkOutput("t1_pending_n", {24'b0, pending}, 32'h90);
      applyStimulus('0, 1'b1);
      checkOutput("t1_valid_n1", {31'b0, evt_valid}, 1);
      checkOutput("t1_pending_n1", {24'b0, pending}, 32'h80);
      applyStimulus('0, 1'b1);
      checkOutput("t1_idx_n2", {29'b0, evt_idx}, 7);
      checkOutput("t1_pending_n2", {24'b0, pending}, 0);
      applyStimulus('0, 1'b1);
      checkOutput("t1_valid_n3", {31'b0, evt_valid}, 0);
      checkOutput("t1_sb_empty", expq.size(), 0);

      // Fill the FIFO while the sink stalls. The fifth event waits in pending.
      doReset();
      for (int i = 0; i < 5; i++) begin
         expectEvt(i, i, 1'b0);
         applyStimulus(WIDTH'(1) << i, 1'b0);
      end
      for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0);
      checkOutput("t2_pending", {24'b0, pending}, 32'h10);
      checkOutput("t2_valid", {31'b0, evt_valid}, 1);
      checkOutput("t2_head_idx", {29'b0, evt_idx}, 0);
      checkOutput("t2_head_ts", {16'b0, evt_ts}, 0);
      drain("t2", 20);

      // Merge pulses into a bit that is stuck pending behind a full FIFO.
      doReset();
      expectEvt(0, 0, 1'b0);
      applyStimulus(8'h01, 1'b0);
      expectEvt(1, 1, 1'b0);
      applyStimulus(8'h02, 1'b0);
      expectEvt(3, 2, 1'b0);
      applyStimulus(8'h08, 1'b0);
      expectEvt(4, 3, 1'b0);
      applyStimulus(8'h10, 1'b0);
      expectEvt(2, 4, 1'b1);
      applyStimulus(8'h04, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(8'h04, 1'b0);
      checkOutput("t3_drop", {24'b0, drop_cnt}, 3);
      checkOutput("t3_pending", {24'b0, pending}, 32'h04);
      drain("t3", 20);
      checkOutput("t3_drop_after", {24'b0, drop_cnt}, 3);

      // Saturate the drop counter with every bit pulsing continuously.
      doReset();
      for (int i = 0; i < 4; i++) expectEvt(0, i, 1'b0);
      expectEvt(0, 4, 1'b1);
      for (int i = 1; i < WIDTH; i++) expectEvt(i, 0, 1'b1);
      for (int i = 0; i < 300; i++) applyStimulus(8'hFF, 1'b0);
      checkOutput("t4_drop_sat", {24'b0, drop_cnt}, 255);
      checkOutput("t4_pending", {24'b0, pending}, 32'hFF);
      for (int i = 0; i < 5; i++) applyStimulus(8'hFF, 1'b0);
      checkOutput("t4_drop_hold", {24'b0, drop_cnt}, 255);
      drain("t4", 40);
      checkOutput("t4_drop_after", {24'b0, drop_cnt}, 255);

      // A bit pulses again on the same cycle it is dispatched. This starts a
      // new event rather than merging into the one that is leaving.
      doReset();
      expectEvt(3, 0, 1'b0);
      expectEvt(3, 1, 1'b0);
      applyStimulus(8'h08, 1'b1);
      applyStimulus(8'h08, 1'b1);
      checkOutput("t5_pending", {24'b0, pending}, 32'h08);
      checkOutput("t5_drop", {24'b0, drop_cnt}, 0);
      drain("t5", 20);
      checkOutput("t5_drop_after", {24'b0, drop_cnt}, 0);

      // Assert reset between clock edges while events are queued.
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(8'h03, 1'b0);
      checkOutput("t6_pre_drop_nz", {31'b0, (drop_cnt != 8'd0)}, 1);
      checkOutput("t6_pre_valid", {31'b0, evt_valid}, 1);
      #2;
      rst_n = 1'b0;
      expq.delete();
      #1;
      checkOutput("t6_async_valid", {31'b0, evt_valid}, 0);
      checkOutput("t6_async_pending", {24'b0, pending}, 0);
      checkOutput("t6_async_drop", {24'b0, drop_cnt}, 0);
      pulse_in = '0;
      step();
      step();
      rst_n = 1'b1;
      expectEvt(5, 0, 1'b0);
      applyStimulus(8'h20, 1'b1);
      drain("t6", 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
